rand_frame_ctrl: RTL

- Bit-serial framing controller that sequences the team's PRBS randomizer (1+X14+X15) for packetised transport-stream energy dispersal.
- Accepts a framed serial bitstream, drives the randomizer's load, enable and seed controls, and selects which bits are scrambled, inverted or passed raw.
- Reloads the seed every RELOAD_FRAMES packets and returns the output through a one-stage registered valid/ready stage.
- Sits between the packet source and the modulator; the randomizer core is a separate instance driven through the rnd_* ports.

---
 rtl/rand_pkg.sv | 17 +
 rtl/rand_frame_cnt.sv | 53 +++++
 rtl/rand_frame_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/rand_pkg.sv
// Shared constants and state encoding for the transport-stream randomizer framing controller.
package rand_pkg;

  localparam int FRAME_BITS    = 1504;
  localparam int SYNC_BITS     = 8;
  localparam int RELOAD_FRAMES = 8;

  // Bit 1 is the leftmost bit of the literal.
  localparam logic [1:15] DEFAULT_SEED = 15'b100101010000000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SYNC    = 2'd1,
    ST_PAYLOAD = 2'd2
  } frame_state_t;

endpackage

// File: rtl/rand_frame_cnt.sv
// Bit-within-packet and packet-within-seed-group counters, with wrap and forced resync.
module rand_frame_cnt
  import rand_pkg::*;
#(
  parameter  int FRAME_BITS_P    = FRAME_BITS,
  parameter  int SYNC_BITS_P     = SYNC_BITS,
  parameter  int RELOAD_FRAMES_P = RELOAD_FRAMES,
  localparam int BW              = $clog2(FRAME_BITS_P),
  localparam int FW              = (RELOAD_FRAMES_P > 1) ? $clog2(RELOAD_FRAMES_P) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_adv,
  input  logic          i_restart,
  output logic [BW-1:0] o_bit_cnt,
  output logic [BW-1:0] o_bit_idx,
  output logic [FW-1:0] o_frm_idx,
  output logic          o_next_in_sync
);

  logic [BW-1:0] r_bit_cnt;
  logic [FW-1:0] r_frm_cnt;
  logic [BW-1:0] w_bit_nxt;
  logic [FW-1:0] w_frm_nxt;

  // A restart makes the current bit behave as bit 0 of packet 0.
  assign o_bit_cnt = r_bit_cnt;
  assign o_bit_idx = i_restart ? '0 : r_bit_cnt;
  assign o_frm_idx = i_restart ? '0 : r_frm_cnt;

  always_comb begin
    w_bit_nxt = o_bit_idx + BW'(1);
    w_frm_nxt = o_frm_idx;
    if (o_bit_idx == BW'(FRAME_BITS_P - 1)) begin
      w_bit_nxt = '0;
      w_frm_nxt = (o_frm_idx == FW'(RELOAD_FRAMES_P - 1)) ? '0 : o_frm_idx + FW'(1);
    end
  end

  assign o_next_in_sync = (w_bit_nxt < BW'(SYNC_BITS_P));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt <= '0;
      r_frm_cnt <= '0;
    end else if (i_adv) begin
      r_bit_cnt <= w_bit_nxt;
      r_frm_cnt <= w_frm_nxt;
    end
  end

endmodule

// File: rtl/rand_frame_ctrl.sv
// Sequences an external 1+X14+X15 randomizer over a framed bitstream and
// registers the scrambled/inverted/raw result into a one-deep valid/ready stage.
module rand_frame_ctrl
  import rand_pkg::*;
#(
  parameter  int          FRAME_BITS_P    = FRAME_BITS,
  parameter  int          SYNC_BITS_P     = SYNC_BITS,
  parameter  int          RELOAD_FRAMES_P = RELOAD_FRAMES,
  parameter  logic [1:15] SEED            = DEFAULT_SEED,
  localparam int          BW              = $clog2(FRAME_BITS_P),
  localparam int          FW              = (RELOAD_FRAMES_P > 1) ? $clog2(RELOAD_FRAMES_P) : 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        s_data,
  input  logic        s_sof,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_data,
  output logic        m_sof,
  input  logic        cfg_bypass,
  output logic        rnd_ld,
  output logic        rnd_en,
  output logic [1:15] rnd_seed,
  output logic        rnd_din,
  input  logic        rnd_dout,
  output logic        frame_err
);

  frame_state_t  r_state;
  frame_state_t  w_state_nxt;
  logic          r_m_valid;
  logic          r_m_data;
  logic          r_m_sof;
  logic          r_frame_err;
  logic          r_bypass;

  logic          w_xfer;
  logic          w_sof_hit;
  logic          w_restart;
  logic          w_err;
  logic          w_adv;
  logic          w_in_sync;
  logic          w_bit0;
  logic          w_frame0;
  logic          w_out_bit;
  logic [BW-1:0] w_bit_cnt;
  logic [BW-1:0] w_bit_idx;
  logic [FW-1:0] w_frm_idx;
  logic          w_next_in_sync;

  assign s_ready   = (r_state == ST_IDLE) || !r_m_valid || m_ready;
  assign w_xfer    = s_valid && s_ready;
  assign w_sof_hit = w_xfer && s_sof;

  // An s_sof away from bit 0 while framed is an error and forces a fresh seed group.
  assign w_err     = w_sof_hit && (r_state != ST_IDLE) && (w_bit_cnt != '0);
  assign w_restart = w_err || (w_sof_hit && (r_state == ST_IDLE));
  assign w_adv     = w_xfer && ((r_state != ST_IDLE) || w_restart);

  assign w_in_sync = (r_state == ST_SYNC) || w_restart;
  assign w_bit0    = (w_bit_idx == '0);
  assign w_frame0  = (w_frm_idx == '0);

  rand_frame_cnt #(
    .FRAME_BITS_P    (FRAME_BITS_P),
    .SYNC_BITS_P     (SYNC_BITS_P),
    .RELOAD_FRAMES_P (RELOAD_FRAMES_P)
  ) u_cnt (
    .clk            (clk),
    .rst            (rst),
    .i_adv          (w_adv),
    .i_restart      (w_restart),
    .o_bit_cnt      (w_bit_cnt),
    .o_bit_idx      (w_bit_idx),
    .o_frm_idx      (w_frm_idx),
    .o_next_in_sync (w_next_in_sync)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    w_state_nxt = r_state;
    rnd_en      = 1'b0;
    rnd_ld      = 1'b0;
    w_out_bit   = 1'b0;
    if (w_adv) begin
      w_state_nxt = w_next_in_sync ? ST_SYNC : ST_PAYLOAD;
      if (w_in_sync) begin
        // Group-leading sync is inverted and holds the LFSR after the seed load.
        w_out_bit = w_frame0 ? ~s_data : s_data;
        rnd_en    = !w_frame0 || w_bit0;
        rnd_ld    = w_frame0 && w_bit0;
      end else begin
        w_out_bit = r_bypass ? s_data : rnd_dout;
        rnd_en    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_m_valid   <= 1'b0;
      r_m_data    <= 1'b0;
      r_m_sof     <= 1'b0;
      r_frame_err <= 1'b0;
      r_bypass    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_frame_err <= w_err;
      if (w_adv && w_bit0) r_bypass <= cfg_bypass;
      if (w_adv) begin
        r_m_valid <= 1'b1;
        r_m_data  <= w_out_bit;
        r_m_sof   <= w_bit0;
      end else if (m_ready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign m_valid   = r_m_valid;
  assign m_data    = r_m_data;
  assign m_sof     = r_m_sof;
  assign frame_err = r_frame_err;
  assign rnd_seed  = SEED;
  assign rnd_din   = s_data;

endmodule
